egress_arbiter: RTL and testbench
=================================

EGRESS_ARBITER -- requirements
Module: egress_arbiter

Interface
REQ-001 Parameter: data_width, default 6, width of every data word.
REQ-002 Parameter: route_bit, default 4, index of the data bit that selects the destination FIFO.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-005 Port: init  input  1  initialisation request; held high to enter/stay in INIT.
REQ-006 Port: data_out_VC0  input  data_width  head word of VC0 FIFO; valid the cycle after pop_VC0_fifo.
REQ-007 Port: empty_fifo_VC0  input  1  VC0 FIFO empty.
REQ-008 Port: data_out_VC1  input  data_width  head word of VC1 FIFO; valid the cycle after pop_VC1_fifo.
REQ-009 Port: empty_fifo_VC1  input  1  VC1 FIFO empty.
REQ-010 Port: almost_full_fifo_D0 / almost_full_fifo_D1  input  1 each  destination FIFO back-pressure.
REQ-011 Port: pop_VC0_fifo / pop_VC1_fifo  output  1 each  read strobes to VC FIFOs.
REQ-012 Port: push_D0 / push_D1  output  1 each  write strobes to destination FIFOs.
REQ-013 Port: data_out_D0 / data_out_D1  output  data_width each  words to destination FIFOs.
REQ-014 Port: state  output  4  one-hot state: RESET=0001, INIT=0010, IDLE=0100, ACTIVE=1000.
REQ-015 Port: idle_out  output  1  high when state is IDLE.
REQ-016 Port: count_D0 / count_D1  output  5 each  words pushed to D0 / D1.

Function
REQ-017 Transitions: RESET->INIT on first clk edge with reset high; any non-RESET state->INIT when init=1; INIT->IDLE when init=0; IDLE->ACTIVE when either VC FIFO not empty; ACTIVE->IDLE when both VC FIFOs empty and no word in flight.
REQ-018 Pops only in ACTIVE, and only when almost_full_fifo_D0=0 and almost_full_fifo_D1=0 (back-pressure on either stalls both).
REQ-019 Priority: pop_VC0_fifo = ACTIVE & !empty_fifo_VC0 & no back-pressure; pop_VC1_fifo = ACTIVE & empty_fifo_VC0 & !empty_fifo_VC1 & no back-pressure; never both high.
REQ-020 Pop outputs combinational from registered state and current inputs.
REQ-021 Pipeline: pop at edge N registers source tag; at edge N+1 the word from the tagged VC is registered to the destination; push seen during cycle N+1..N+2, i.e. push follows pop by exactly 2 cycles; one word per cycle sustained.
REQ-022 Routing: word bit route_bit=0 -> push_D0 with data_out_D0=word; =1 -> push_D1 with data_out_D1=word; exactly one push per moved word.
REQ-023 Non-pushed destination data output holds its previous value; push strobes high exactly one cycle per word.
REQ-024 Words already popped complete their push even if back-pressure or init asserts afterward; entering INIT drops no in-flight word.
REQ-025 count_Dx increments by 1 on each push_Dx, wraps 31->0, clears to 0 while in INIT.
REQ-026 Pops stop during INIT; empty-flag changes outside ACTIVE produce no pops.

Reset
REQ-027 reset=0 asynchronously forces: state=0001, idle_out=0, all pops/pushes=0, data_out_D0/D1=0, counts=0, in-flight pipeline cleared.
REQ-028 Reset mid-operation discards in-flight words; no push may appear after reset assertion.

Verification
REQ-029 Reset release, init 1 cycle then 0, both VCs empty -> state 0001->0010->0100, idle_out=1, no pops.
REQ-030 VC0 holds 0x05, 0x15, VC1 empty -> two pops on VC0; push_D0 with 0x05, then push_D1 with 0x15, each 2 cycles after its pop; count_D0=1, count_D1=1.
REQ-031 Both VCs non-empty (VC0: 0x01, VC1: 0x12) -> VC0 popped first; VC1 popped only once empty_fifo_VC0=1; pushes D0=0x01, then D1=0x12.
REQ-032 almost_full_fifo_D1=1 while VC0 non-empty -> pop_VC0_fifo=0 until it drops; words popped before it rose still pushed.
REQ-033 32 words with bit4=0 -> count_D0 wraps to 0; count_D1 stays 0.
REQ-034 reset=0 one cycle after a pop -> no push, all outputs 0 in same cycle, state=0001.

Source files
------------

// File: rtl/egress_arbiter.sv
// Egress arbiter: drains two virtual-channel FIFOs (VC0 has priority) into two
// destination FIFOs, routing each word on one data bit through a two-stage pipeline.
module egress_arbiter #(
  parameter int data_width = 6,
  parameter int route_bit  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [data_width-1:0] data_out_VC0,
  input  logic                  empty_fifo_VC0,
  input  logic [data_width-1:0] data_out_VC1,
  input  logic                  empty_fifo_VC1,
  input  logic                  almost_full_fifo_D0,
  input  logic                  almost_full_fifo_D1,
  output logic                  pop_VC0_fifo,
  output logic                  pop_VC1_fifo,
  output logic                  push_D0,
  output logic                  push_D1,
  output logic [data_width-1:0] data_out_D0,
  output logic [data_width-1:0] data_out_D1,
  output logic [3:0]            state,
  output logic                  idle_out,
  output logic [4:0]            count_D0,
  output logic [4:0]            count_D1
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_t;

  state_t                state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic                  tag_q, tag_d;
  logic                  push_d0_q, push_d0_d;
  logic                  push_d1_q, push_d1_d;
  logic [data_width-1:0] data_d0_q, data_d0_d;
  logic [data_width-1:0] data_d1_q, data_d1_d;
  logic [4:0]            count_d0_q, count_d0_d;
  logic [4:0]            count_d1_q, count_d1_d;

  logic                  pop0, pop1, back_pressure;
  logic [data_width-1:0] word;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:  state_d = ST_INIT;
      ST_INIT:   if (!init) state_d = ST_IDLE;
      ST_IDLE:   if (!empty_fifo_VC0 || !empty_fifo_VC1) state_d = ST_ACTIVE;
      ST_ACTIVE: if (empty_fifo_VC0 && empty_fifo_VC1 && !inflight_q) state_d = ST_IDLE;
      default:   state_d = ST_RESET;
    endcase
    if (init && state_q != ST_RESET) state_d = ST_INIT;
  end

  // Back-pressure from either destination stalls both sources.
  always_comb begin
    back_pressure = almost_full_fifo_D0 | almost_full_fifo_D1;
    pop0 = (state_q == ST_ACTIVE) && !empty_fifo_VC0 && !back_pressure;
    pop1 = (state_q == ST_ACTIVE) && empty_fifo_VC0 && !empty_fifo_VC1 && !back_pressure;
  end

  // Stage 1 remembers which VC was popped; stage 2 captures its word one cycle later.
  always_comb begin
    inflight_d = pop0 | pop1;
    tag_d      = pop1;
    word       = tag_q ? data_out_VC1 : data_out_VC0;
    push_d0_d  = inflight_q && !word[route_bit];
    push_d1_d  = inflight_q && word[route_bit];
    data_d0_d  = push_d0_d ? word : data_d0_q;
    data_d1_d  = push_d1_d ? word : data_d1_q;
    count_d0_d = count_d0_q + {4'b0000, push_d0_d};
    count_d1_d = count_d1_q + {4'b0000, push_d1_d};
    if (state_q == ST_INIT) begin
      count_d0_d = '0;
      count_d1_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RESET;
      inflight_q <= 1'b0;
      tag_q      <= 1'b0;
      push_d0_q  <= 1'b0;
      push_d1_q  <= 1'b0;
      data_d0_q  <= '0;
      data_d1_q  <= '0;
      count_d0_q <= '0;
      count_d1_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      push_d0_q  <= push_d0_d;
      push_d1_q  <= push_d1_d;
      data_d0_q  <= data_d0_d;
      data_d1_q  <= data_d1_d;
      count_d0_q <= count_d0_d;
      count_d1_q <= count_d1_d;
    end
  end

  assign pop_VC0_fifo = pop0;
  assign pop_VC1_fifo = pop1;
  assign push_D0      = push_d0_q;
  assign push_D1      = push_d1_q;
  assign data_out_D0  = data_d0_q;
  assign data_out_D1  = data_d1_q;
  assign state        = state_q;
  assign idle_out     = (state_q == ST_IDLE);
  assign count_D0     = count_d0_q;
  assign count_D1     = count_d1_q;

endmodule

// File: tb/tb_egress_arbiter.sv
// Directed bench for egress_arbiter: a queue-based VC FIFO model feeds the DUT and
// a per-cycle monitor logs pops and pushes for comparison against hand-computed values.
module tb_egress_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       init;
  logic [5:0] data_out_VC0, data_out_VC1;
  logic       empty_fifo_VC0, empty_fifo_VC1;
  logic       almost_full_fifo_D0, almost_full_fifo_D1;
  logic       pop_VC0_fifo, pop_VC1_fifo, push_D0, push_D1;
  logic [5:0] data_out_D0, data_out_D1;
  logic [3:0] state;
  logic       idle_out;
  logic [4:0] count_D0, count_D1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [5:0] q0[$];
  logic [5:0] q1[$];
  int         popSrc[$];
  int         popCyc[$];
  int         logDest[$];
  logic [5:0] logData[$];
  logic       pend0, pend1;

  egress_arbiter #(.data_width(6), .route_bit(4)) dut (
    .clk(clk), .reset(reset), .init(init),
    .data_out_VC0(data_out_VC0), .empty_fifo_VC0(empty_fifo_VC0),
    .data_out_VC1(data_out_VC1), .empty_fifo_VC1(empty_fifo_VC1),
    .almost_full_fifo_D0(almost_full_fifo_D0), .almost_full_fifo_D1(almost_full_fifo_D1),
    .pop_VC0_fifo(pop_VC0_fifo), .pop_VC1_fifo(pop_VC1_fifo),
    .push_D0(push_D0), .push_D1(push_D1),
    .data_out_D0(data_out_D0), .data_out_D1(data_out_D1),
    .state(state), .idle_out(idle_out),
    .count_D0(count_D0), .count_D1(count_D1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: monitor at the falling edge, then the FIFO model reacts after the rising edge.
  task automatic tick();
    @(negedge clk);
    pend0 = pop_VC0_fifo;
    pend1 = pop_VC1_fifo;
    if (pop_VC0_fifo || pop_VC1_fifo) begin
      checkOutput("pop_exclusive", 32'(pop_VC0_fifo & pop_VC1_fifo), 32'd0);
      popSrc.push_back(pop_VC1_fifo ? 1 : 0);
      popCyc.push_back(cyc);
    end
    if (push_D0 || push_D1) begin
      checkOutput("push_exclusive", 32'(push_D0 & push_D1), 32'd0);
      logDest.push_back(push_D1 ? 1 : 0);
      logData.push_back(push_D1 ? data_out_D1 : data_out_D0);
      if (popCyc.size() > 0) checkOutput("push_latency", 32'(cyc - popCyc.pop_front()), 32'd2);
      else checkOutput("push_without_pop", 32'd1, 32'd0);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (pend0 && q0.size() > 0) data_out_VC0 = q0.pop_front();
    if (pend1 && q1.size() > 0) data_out_VC1 = q1.pop_front();
    empty_fifo_VC0 = (q0.size() == 0);
    empty_fifo_VC1 = (q1.size() == 0);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input int vc, input logic [5:0] word);
    if (vc == 0) q0.push_back(word);
    else q1.push_back(word);
    empty_fifo_VC0 = (q0.size() == 0);
    empty_fifo_VC1 = (q1.size() == 0);
  endtask

  task automatic clearLogs();
    popSrc.delete();
    logDest.delete();
    logData.delete();
  endtask

  task automatic checkPush(input string tag, input int idx, input int dest, input logic [5:0] data);
    if (idx < logDest.size()) begin
      checkOutput({tag, "_dest"}, 32'(logDest[idx]), 32'(dest));
      checkOutput({tag, "_data"}, 32'(logData[idx]), 32'(data));
    end else begin
      checkOutput({tag, "_missing"}, 32'(logDest.size()), 32'(idx + 1));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_state"}, 32'(state), 32'h1);
    checkOutput({tag, "_idle"}, 32'(idle_out), 32'd0);
    checkOutput({tag, "_pops"}, 32'({pop_VC0_fifo, pop_VC1_fifo}), 32'd0);
    checkOutput({tag, "_pushes"}, 32'({push_D0, push_D1}), 32'd0);
    checkOutput({tag, "_data"}, 32'({data_out_D0, data_out_D1}), 32'd0);
    checkOutput({tag, "_counts"}, 32'({count_D0, count_D1}), 32'd0);
  endtask

  task automatic bringUp(input string tag);
    init = 1'b1;
    reset = 1'b1;
    tick();
    checkOutput({tag, "_init_state"}, 32'(state), 32'h2);
    init = 1'b0;
    tick();
    checkOutput({tag, "_idle_state"}, 32'(state), 32'h4);
    checkOutput({tag, "_idle_out"}, 32'(idle_out), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    init = 1'b0;
    data_out_VC0 = '0;
    data_out_VC1 = '0;
    empty_fifo_VC0 = 1'b1;
    empty_fifo_VC1 = 1'b1;
    almost_full_fifo_D0 = 1'b0;
    almost_full_fifo_D1 = 1'b0;
    pend0 = 1'b0;
    pend1 = 1'b0;
    #1 reset = 1'b0;
    #2;
    checkResetOutputs("por");
    @(posedge clk);
    #2;

    // Reset release with a one-cycle init pulse, both VCs empty.
    bringUp("startup");
    ticks(3);
    checkOutput("startup_no_pops", 32'(popSrc.size()), 32'd0);
    checkOutput("startup_still_idle", 32'(state), 32'h4);

    // Two words on VC0 routed to different destinations.
    clearLogs();
    applyStimulus(0, 6'h05);
    applyStimulus(0, 6'h15);
    ticks(8);
    checkOutput("vc0_pop_count", 32'(popSrc.size()), 32'd2);
    checkOutput("vc0_push_count", 32'(logDest.size()), 32'd2);
    checkPush("vc0_w0", 0, 0, 6'h05);
    checkPush("vc0_w1", 1, 1, 6'h15);
    checkOutput("vc0_count_D0", 32'(count_D0), 32'd1);
    checkOutput("vc0_count_D1", 32'(count_D1), 32'd1);
    checkOutput("vc0_back_idle", 32'(state), 32'h4);

    // Both VCs loaded: VC0 must win.
    clearLogs();
    applyStimulus(0, 6'h01);
    applyStimulus(1, 6'h12);
    ticks(8);
    checkOutput("prio_pop_count", 32'(popSrc.size()), 32'd2);
    if (popSrc.size() == 2) begin
      checkOutput("prio_first_vc", 32'(popSrc[0]), 32'd0);
      checkOutput("prio_second_vc", 32'(popSrc[1]), 32'd1);
    end
    checkPush("prio_w0", 0, 0, 6'h01);
    checkPush("prio_w1", 1, 1, 6'h12);
    checkOutput("prio_count_D0", 32'(count_D0), 32'd2);
    checkOutput("prio_count_D1", 32'(count_D1), 32'd2);

    // Back-pressure held before any pop.
    clearLogs();
    almost_full_fifo_D1 = 1'b1;
    applyStimulus(0, 6'h03);
    applyStimulus(0, 6'h07);
    ticks(5);
    checkOutput("bp_no_pops", 32'(popSrc.size()), 32'd0);
    checkOutput("bp_active", 32'(state), 32'h8);
    checkOutput("bp_pop_low", 32'(pop_VC0_fifo), 32'd0);
    almost_full_fifo_D1 = 1'b0;
    ticks(8);
    checkOutput("bp_release_pushes", 32'(logDest.size()), 32'd2);
    checkPush("bp_w0", 0, 0, 6'h03);
    checkPush("bp_w1", 1, 0, 6'h07);

    // Back-pressure rising after one pop: the popped word still completes.
    clearLogs();
    applyStimulus(0, 6'h30);
    applyStimulus(0, 6'h31);
    ticks(2);
    almost_full_fifo_D0 = 1'b1;
    ticks(6);
    checkOutput("bp_mid_pops", 32'(popSrc.size()), 32'd1);
    checkOutput("bp_mid_pushes", 32'(logDest.size()), 32'd1);
    checkPush("bp_mid_w0", 0, 1, 6'h30);
    almost_full_fifo_D0 = 1'b0;
    ticks(6);
    checkPush("bp_mid_w1", 1, 1, 6'h31);
    checkOutput("bp_count_D0", 32'(count_D0), 32'd4);
    checkOutput("bp_count_D1", 32'(count_D1), 32'd4);
    checkOutput("bp_back_idle", 32'(state), 32'h4);

    // Init clears counters, then 32 D0 words wrap count_D0 back to zero.
    init = 1'b1;
    ticks(2);
    checkOutput("init_state", 32'(state), 32'h2);
    checkOutput("init_count_D0", 32'(count_D0), 32'd0);
    checkOutput("init_count_D1", 32'(count_D1), 32'd0);
    init = 1'b0;
    tick();
    checkOutput("init_exit", 32'(state), 32'h4);
    clearLogs();
    for (int i = 0; i < 32; i++) begin
      logic [5:0] w;
      w = {i[4], 1'b0, i[3:0]};
      applyStimulus(0, w);
    end
    ticks(40);
    checkOutput("wrap_push_count", 32'(logDest.size()), 32'd32);
    for (int i = 0; i < 32 && i < logDest.size(); i++) begin
      logic [5:0] w;
      w = {i[4], 1'b0, i[3:0]};
      checkPush("wrap_word", i, 0, w);
    end
    checkOutput("wrap_count_D0", 32'(count_D0), 32'd0);
    checkOutput("wrap_count_D1", 32'(count_D1), 32'd0);
    checkOutput("wrap_last_D0", 32'(data_out_D0), 32'h2F);
    checkOutput("wrap_hold_D1", 32'(data_out_D1), 32'h31);

    // Reset one cycle after a pop: the in-flight word is discarded.
    clearLogs();
    applyStimulus(0, 6'h15);
    applyStimulus(0, 6'h05);
    ticks(3);
    checkOutput("rst_pre_push_D1", 32'(push_D1), 32'd1);
    checkOutput("rst_pre_count_D1", 32'(count_D1), 32'd1);
    checkOutput("rst_pre_data_D1", 32'(data_out_D1), 32'h15);
    reset = 1'b0;
    #1;
    checkResetOutputs("rst_mid");
    popCyc.delete();
    clearLogs();
    ticks(3);
    checkOutput("rst_no_push", 32'(logDest.size()), 32'd0);
    checkOutput("rst_held_state", 32'(state), 32'h1);
    bringUp("restart");
    ticks(3);
    checkOutput("restart_no_push", 32'(logDest.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
